// File: rtl/branch_redirect_ctrl.sv
// Fetch-PC sequencer: merges the EX-stage branch/jump redirect with the load-use
// stall and the instruction-memory ready handshake, holding a redirect while imem is busy.
module branch_redirect_ctrl #(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             pc_sel,
   input  logic [31:0]      br_pc,
   input  logic [PC_W-1:0]  cur_pc,
   input  logic             hz_stall,
   input  logic             imem_ready,
   output logic [PC_W-1:0]  pc_next,
   output logic             pc_write,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             stall_ifid,
   output logic             busy,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam logic ST_RUN        = 1'b0;
   localparam logic ST_REDIR_WAIT = 1'b1;

   logic             state_q, state_d;
   logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
   logic             misalign_err_q, misalign_err_d;
   logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

   logic             redirect;
   logic             tgt_bad;
   logic [PC_W-1:0]  tgt;
   logic [PC_W-1:0]  seq;

   assign redirect = ex_valid & pc_sel;
   assign tgt      = {br_pc[PC_W-1:2], 2'b00};
   assign seq      = cur_pc + PC_W'(4);
   // Any set bit at or above PC_W means the target does not fit the fetch PC.
   assign tgt_bad  = (br_pc[1:0] != 2'b00) || ((br_pc >> PC_W) != 32'd0);

   always_comb begin
      state_d        = state_q;
      pend_tgt_d     = pend_tgt_q;
      misalign_err_d = misalign_err_q;
      redirect_cnt_d = redirect_cnt_q;

      pc_next    = seq;
      pc_write   = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      stall_ifid = 1'b0;
      busy       = 1'b0;

      if (state_q == ST_RUN) begin
         if (redirect) begin
            // Redirect wins over hz_stall: the stalled instruction is wrong-path.
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (redirect_cnt_q != '1)
               redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
            if (tgt_bad)
               misalign_err_d = 1'b1;
            if (imem_ready) begin
               pc_next  = tgt;
               pc_write = 1'b1;
            end else begin
               pend_tgt_d = tgt;
               state_d    = ST_REDIR_WAIT;
            end
         end else if (hz_stall) begin
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
         end else begin
            pc_write   = imem_ready;
            stall_ifid = ~imem_ready;
         end
      end else begin
         busy       = 1'b1;
         pc_next    = pend_tgt_q;
         pc_write   = imem_ready;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         if (imem_ready)
            state_d = ST_RUN;
      end

      if (!reset) begin
         pc_next    = '0;
         pc_write   = 1'b0;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         stall_ifid = 1'b0;
         busy       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_RUN;
         pend_tgt_q     <= '0;
         misalign_err_q <= 1'b0;
         redirect_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         pend_tgt_q     <= pend_tgt_d;
         misalign_err_q <= misalign_err_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign misalign_err = misalign_err_q;
   assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a second instance with a 4-bit counter
// shares all inputs to exercise counter saturation.
module tb_branch_redirect_ctrl;

   localparam int PC_W = 9;

   logic            clk = 1'b0;
   logic            reset;
   logic            ex_valid;
   logic            pc_sel;
   logic [31:0]     br_pc;
   logic [PC_W-1:0] cur_pc;
   logic            hz_stall;
   logic            imem_ready;

   logic [PC_W-1:0] pc_next,  pc_next4;
   logic            pc_write, pc_write4;
   logic            flush_ifid, flush_ifid4;
   logic            flush_idex, flush_idex4;
   logic            stall_ifid, stall_ifid4;
   logic            busy, busy4;
   logic            misalign_err, misalign_err4;
   logic [15:0]     redirect_cnt;
   logic [3:0]      redirect_cnt4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .pc_sel(pc_sel), .br_pc(br_pc),
      .cur_pc(cur_pc), .hz_stall(hz_stall), .imem_ready(imem_ready),
      .pc_next(pc_next), .pc_write(pc_write), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .stall_ifid(stall_ifid), .busy(busy),
      .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
   );

   branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .pc_sel(pc_sel), .br_pc(br_pc),
      .cur_pc(cur_pc), .hz_stall(hz_stall), .imem_ready(imem_ready),
      .pc_next(pc_next4), .pc_write(pc_write4), .flush_ifid(flush_ifid4),
      .flush_idex(flush_idex4), .stall_ifid(stall_ifid4), .busy(busy4),
      .misalign_err(misalign_err4), .redirect_cnt(redirect_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid = 1'b0; pc_sel = 1'b0; br_pc = 32'd0; hz_stall = 1'b0;
   endtask

   initial begin
      reset = 1'b0; idle(); cur_pc = '0; imem_ready = 1'b0;
      #2;
      chk("rst_pc_write", 32'(pc_write), 32'd0);
      chk("rst_flush_ifid", 32'(flush_ifid), 32'd1);
      chk("rst_flush_idex", 32'(flush_idex), 32'd1);
      chk("rst_stall", 32'(stall_ifid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pc_next", 32'(pc_next), 32'd0);
      chk("rst_cnt", 32'(redirect_cnt), 32'd0);
      chk("rst_err", 32'(misalign_err), 32'd0);
      step();
      reset = 1'b1;
      step();

      // sequential fetch
      cur_pc = 9'h010; imem_ready = 1'b1; #1;
      chk("seq_pc_write", 32'(pc_write), 32'd1);
      chk("seq_pc_next", 32'(pc_next), 32'h014);
      chk("seq_flush_ifid", 32'(flush_ifid), 32'd0);
      chk("seq_flush_idex", 32'(flush_idex), 32'd0);
      chk("seq_stall", 32'(stall_ifid), 32'd0);
      chk("seq_cnt", 32'(redirect_cnt), 32'd0);

      // redirect with imem ready
      ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h40; #1;
      chk("br_pc_next", 32'(pc_next), 32'h040);
      chk("br_pc_write", 32'(pc_write), 32'd1);
      chk("br_flush_ifid", 32'(flush_ifid), 32'd1);
      chk("br_flush_idex", 32'(flush_idex), 32'd1);
      step();
      idle();
      chk("br_cnt", 32'(redirect_cnt), 32'd1);
      chk("br_busy_after", 32'(busy), 32'd0);

      // redirect while imem busy for three cycles
      ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h80; imem_ready = 1'b0; #1;
      chk("w1_pc_write", 32'(pc_write), 32'd0);
      chk("w1_flush_ifid", 32'(flush_ifid), 32'd1);
      chk("w1_flush_idex", 32'(flush_idex), 32'd1);
      step();
      br_pc = 32'h100; #1;
      chk("w2_busy", 32'(busy), 32'd1);
      chk("w2_pc_write", 32'(pc_write), 32'd0);
      chk("w2_pc_next", 32'(pc_next), 32'h080);
      chk("w2_cnt", 32'(redirect_cnt), 32'd2);
      step();
      idle(); #1;
      chk("w3_busy", 32'(busy), 32'd1);
      chk("w3_pc_write", 32'(pc_write), 32'd0);
      chk("w3_pc_next", 32'(pc_next), 32'h080);
      chk("w3_cnt", 32'(redirect_cnt), 32'd2);
      step();
      imem_ready = 1'b1; #1;
      chk("w4_pc_write", 32'(pc_write), 32'd1);
      chk("w4_pc_next", 32'(pc_next), 32'h080);
      chk("w4_stall", 32'(stall_ifid), 32'd0);
      step();
      chk("w_done_busy", 32'(busy), 32'd0);
      chk("w_done_cnt", 32'(redirect_cnt), 32'd2);
      chk("w_done_err", 32'(misalign_err), 32'd0);

      // load-use stall, then stall plus redirect
      cur_pc = 9'h020; hz_stall = 1'b1; #1;
      chk("hz_pc_write", 32'(pc_write), 32'd0);
      chk("hz_stall_ifid", 32'(stall_ifid), 32'd1);
      chk("hz_flush_idex", 32'(flush_idex), 32'd1);
      chk("hz_flush_ifid", 32'(flush_ifid), 32'd0);
      chk("hz_pc_next", 32'(pc_next), 32'h024);
      ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h100; #1;
      chk("hzbr_pc_next", 32'(pc_next), 32'h100);
      chk("hzbr_stall", 32'(stall_ifid), 32'd0);
      chk("hzbr_pc_write", 32'(pc_write), 32'd1);
      step();
      idle();
      chk("hzbr_cnt", 32'(redirect_cnt), 32'd3);

      // misaligned and out-of-range targets
      ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h46; #1;
      chk("mis_pc_next", 32'(pc_next), 32'h044);
      step();
      chk("mis_err", 32'(misalign_err), 32'd1);
      br_pc = 32'h400; #1;
      chk("oor_pc_next", 32'(pc_next), 32'h000);
      step();
      idle();
      chk("oor_err_sticky", 32'(misalign_err), 32'd1);
      chk("oor_cnt", 32'(redirect_cnt), 32'd5);

      // pc_sel without ex_valid is ignored
      pc_sel = 1'b1; br_pc = 32'h0C0; cur_pc = 9'h030; #1;
      chk("nv_pc_next", 32'(pc_next), 32'h034);
      chk("nv_flush_ifid", 32'(flush_ifid), 32'd0);
      step();
      idle();
      chk("nv_cnt", 32'(redirect_cnt), 32'd5);

      // PC wrap and idle imem stall
      cur_pc = 9'h1FC; #1;
      chk("wrap_pc_next", 32'(pc_next), 32'h000);
      imem_ready = 1'b0; #1;
      chk("nrdy_stall", 32'(stall_ifid), 32'd1);
      chk("nrdy_pc_write", 32'(pc_write), 32'd0);
      imem_ready = 1'b1;

      // 12 more redirects -> 17 total
      ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h010;
      for (int i = 0; i < 12; i++) step();
      idle();
      chk("sat_cnt4", 32'(redirect_cnt4), 32'd15);
      chk("sat_cnt16", 32'(redirect_cnt), 32'd17);

      // reset in the middle of a pending redirect
      ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h0A0; imem_ready = 1'b0;
      step();
      idle();
      chk("rw_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0; #1;
      chk("rw_rst_busy", 32'(busy), 32'd0);
      chk("rw_rst_cnt", 32'(redirect_cnt), 32'd0);
      chk("rw_rst_err", 32'(misalign_err), 32'd0);
      chk("rw_rst_pc_next", 32'(pc_next), 32'd0);
      step();
      reset = 1'b1; cur_pc = 9'h050; imem_ready = 1'b1; #1;
      chk("rw_after_busy", 32'(busy), 32'd0);
      chk("rw_after_pc_next", 32'(pc_next), 32'h054);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
